// File: rtl/multi_io_byte_fifo.sv
// Byte-lane FIFO built as a shift register: variable-length write and pop each cycle,
// zero-latency peek of the oldest bytes, and sticky overflow/underflow flags.
module multi_io_byte_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_WR_BYTES = 5,
    parameter int MAX_RD_BYTES = 4,
    parameter int AFULL_THRESH = FIFO_DEPTH - MAX_WR_BYTES
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 clear_err,
    input  logic                                 wr_en,
    input  logic [DATA_WIDTH*MAX_WR_BYTES-1:0]   wr_data,
    input  logic [$clog2(MAX_WR_BYTES+1)-1:0]    wr_len,
    output logic                                 wr_ready,
    input  logic                                 rd_en,
    input  logic [$clog2(MAX_RD_BYTES+1)-1:0]    rd_len,
    output logic [DATA_WIDTH*MAX_RD_BYTES-1:0]   rd_data,
    output logic                                 rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]          data_count,
    output logic                                 empty,
    output logic                                 almost_full,
    output logic                                 full,
    output logic                                 wr_overflow,
    output logic                                 rd_underflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = CW + 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(FIFO_DEPTH);
    localparam logic [AW-1:0] AFULL_A = AW'(AFULL_THRESH);
    localparam logic [AW-1:0] MAXWR_A = AW'(MAX_WR_BYTES);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [CW-1:0]         r_count;
    logic                  r_wr_ovf;
    logic                  r_rd_und;

    logic [DATA_WIDTH-1:0] w_mem_next [FIFO_DEPTH];
    logic [AW-1:0]         w_cnt_a;
    logic [AW-1:0]         w_rd_len_a;
    logic [AW-1:0]         w_wr_len_a;
    logic [AW-1:0]         w_shift;
    logic [AW-1:0]         w_base;
    logic [AW-1:0]         w_wr_add;
    logic [CW-1:0]         w_cnt_next;
    logic                  w_rd_valid;
    logic                  w_rd_acc;
    logic                  w_wr_len_ok;
    logic                  w_wr_ready;
    logic                  w_wr_acc;

    // Count arithmetic is one bit wider than the count so nothing wraps.
    assign w_cnt_a     = AW'(r_count);
    assign w_rd_len_a  = AW'(rd_len);
    assign w_wr_len_a  = AW'(wr_len);

    assign w_rd_valid  = (rd_len != '0) && (w_cnt_a >= w_rd_len_a);
    assign w_rd_acc    = rd_en && w_rd_valid;
    assign w_shift     = w_rd_acc ? w_rd_len_a : '0;
    assign w_base      = w_cnt_a - w_shift;

    // Space freed by a same-cycle pop counts towards the write.
    assign w_wr_len_ok = (wr_len != '0) && (w_wr_len_a <= MAXWR_A);
    assign w_wr_ready  = w_wr_len_ok && ((w_base + w_wr_len_a) <= DEPTH_A);
    assign w_wr_acc    = wr_en && w_wr_ready;
    assign w_wr_add    = w_wr_acc ? w_wr_len_a : '0;
    assign w_cnt_next  = CW'(w_base + w_wr_add);

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            int src;
            int k;
            src = i + int'(w_shift);
            k   = i - int'(w_base);
            w_mem_next[i] = '0;
            if (src < int'(w_cnt_a)) begin
                w_mem_next[i] = r_mem[src];
            end
            if (w_wr_acc && (k >= 0) && (k < int'(w_wr_len_a))) begin
                w_mem_next[i] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else if (flush) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= w_mem_next[i];
            end
            r_count <= w_cnt_next;
        end
    end

    // A new error in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ovf <= 1'b0;
            r_rd_und <= 1'b0;
        end else if (flush) begin
            r_wr_ovf <= 1'b0;
            r_rd_und <= 1'b0;
        end else begin
            r_wr_ovf <= (wr_en && !w_wr_acc) || (r_wr_ovf && !clear_err);
            r_rd_und <= (rd_en && !w_rd_valid) || (r_rd_und && !clear_err);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < MAX_RD_BYTES; j++) begin
            if (j < int'(w_cnt_a)) begin
                rd_data[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[j];
            end
        end
    end

    assign wr_ready     = w_wr_ready;
    assign rd_valid     = w_rd_valid;
    assign data_count   = r_count;
    assign empty        = (r_count == '0);
    assign almost_full  = (w_cnt_a >= AFULL_A);
    assign full         = (w_cnt_a == DEPTH_A);
    assign wr_overflow  = r_wr_ovf;
    assign rd_underflow = r_rd_und;

endmodule

// File: tb/tb_multi_io_byte_fifo.sv
// Bench for multi_io_byte_fifo: directed vectors with hand-computed results, plus a byte
// scoreboard that checks every accepted pop against the bytes expected to leave the FIFO.
module tb_multi_io_byte_fifo;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        clear_err;
    logic        wr_en;
    logic [39:0] wr_data;
    logic [2:0]  wr_len;
    logic        wr_ready;
    logic        rd_en;
    logic [2:0]  rd_len;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [4:0]  data_count;
    logic        empty;
    logic        almost_full;
    logic        full;
    logic        wr_overflow;
    logic        rd_underflow;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];

    multi_io_byte_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .clear_err    (clear_err),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_len       (wr_len),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .rd_len       (rd_len),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .data_count   (data_count),
        .empty        (empty),
        .almost_full  (almost_full),
        .full         (full),
        .wr_overflow  (wr_overflow),
        .rd_underflow (rd_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush     = 1'b0;
        clear_err = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        wr_len    = '0;
        rd_en     = 1'b0;
        rd_len    = '0;
    endtask

    task automatic drive(input bit we, input int wl, input logic [39:0] wd,
                         input bit re, input int rl, input bit fl, input bit ce);
        wr_en     = we;
        wr_len    = 3'(wl);
        wr_data   = wd;
        rd_en     = re;
        rd_len    = 3'(rl);
        flush     = fl;
        clear_err = ce;
    endtask

    task automatic push(input logic [39:0] wd, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(wd[k*8 +: 8]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Scoreboard monitor: every accepted pop must return the oldest expected bytes.
    always @(negedge clk) begin
        if (rst_n && !flush && rd_en && rd_valid) begin
            for (int j = 0; j < int'(rd_len); j++) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_lane%0d: got %0h want no byte (scoreboard empty)", j, rd_data[j*8 +: 8]);
                end else begin
                    chk($sformatf("pop_lane%0d", j), 64'(rd_data[j*8 +: 8]), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(data_count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_afull", 64'(almost_full), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        chk("rst_ovf", 64'(wr_overflow), 64'd0);
        chk("rst_und", 64'(rd_underflow), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Five bytes from empty
        drive(1, 5, 40'h0504030201, 0, 0, 0, 0);
        push(40'h0504030201, 5);
        @(negedge clk);
        chk("w5_ready", 64'(wr_ready), 64'd1);
        step();
        chk("w5_count", 64'(data_count), 64'd5);
        chk("w5_rd_data", 64'(rd_data), 64'h04030201);
        rd_len = 3'd4;
        #1 chk("w5_valid_len4", 64'(rd_valid), 64'd1);
        rd_len = 3'd0;
        #1 chk("w5_valid_len0", 64'(rd_valid), 64'd0);
        rd_len = 3'd5;
        #1 chk("w5_valid_len5", 64'(rd_valid), 64'd1);
        idle();

        // Simultaneous pop of 3 and write of 2
        drive(1, 2, 40'hBBAA, 1, 3, 0, 0);
        push(40'hBBAA, 2);
        step();
        chk("rw_count", 64'(data_count), 64'd4);
        chk("rw_rd_data", 64'(rd_data), 64'hBBAA0504);

        drive(1, 5, 40'h1413121110, 0, 0, 0, 0);
        push(40'h1413121110, 5);
        step();
        drive(1, 5, 40'h1918171615, 0, 0, 0, 0);
        push(40'h1918171615, 5);
        step();
        chk("c14_count", 64'(data_count), 64'd14);
        chk("c14_afull", 64'(almost_full), 64'd1);
        chk("c14_full", 64'(full), 64'd0);

        // Write of 3 at count 14 does not fit
        drive(1, 3, 40'h1C1B1A, 0, 0, 0, 0);
        @(negedge clk);
        chk("c14_ready", 64'(wr_ready), 64'd0);
        step();
        chk("c14_ovf", 64'(wr_overflow), 64'd1);
        chk("c14_count_hold", 64'(data_count), 64'd14);
        chk("c14_data_hold", 64'(rd_data), 64'hBBAA0504);

        // Same write fits once a 2-byte pop frees space
        drive(1, 3, 40'h1C1B1A, 1, 2, 0, 0);
        push(40'h1C1B1A, 3);
        @(negedge clk);
        chk("c14_rd_ready", 64'(wr_ready), 64'd1);
        step();
        chk("c15_count", 64'(data_count), 64'd15);
        chk("c15_rd_data", 64'(rd_data), 64'h1110BBAA);
        chk("c15_ovf_sticky", 64'(wr_overflow), 64'd1);

        drive(0, 0, '0, 0, 0, 0, 1);
        step();
        chk("clr_ovf", 64'(wr_overflow), 64'd0);

        drive(1, 0, 40'hEE, 0, 0, 0, 0);
        @(negedge clk);
        chk("len0_ready", 64'(wr_ready), 64'd0);
        step();
        chk("len0_ovf", 64'(wr_overflow), 64'd1);
        chk("len0_count", 64'(data_count), 64'd15);

        drive(1, 7, 40'hEE, 0, 0, 0, 1);
        step();
        chk("clr_vs_err_ovf", 64'(wr_overflow), 64'd1);
        chk("len7_count", 64'(data_count), 64'd15);
        drive(0, 0, '0, 0, 0, 0, 1);
        step();
        chk("clr2_ovf", 64'(wr_overflow), 64'd0);

        // Pop 4 and write 5 at count 15 lands exactly on full
        drive(1, 5, 40'h21201F1E1D, 1, 4, 0, 0);
        push(40'h21201F1E1D, 5);
        step();
        chk("full_count", 64'(data_count), 64'd16);
        chk("full_full", 64'(full), 64'd1);
        chk("full_afull", 64'(almost_full), 64'd1);
        chk("full_rd_data", 64'(rd_data), 64'h15141312);
        wr_len = 3'd1;
        #1 chk("full_ready", 64'(wr_ready), 64'd0);
        idle();
        drive(1, 1, 40'h77, 0, 0, 0, 0);
        step();
        chk("full_ovf", 64'(wr_overflow), 64'd1);

        // Flush beats same-cycle write and read
        drive(1, 1, 40'h88, 1, 4, 1, 0);
        step();
        exp_q.delete();
        chk("flush_count", 64'(data_count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_rd_data", 64'(rd_data), 64'h0);
        chk("flush_ovf", 64'(wr_overflow), 64'd0);
        chk("flush_full", 64'(full), 64'd0);

        // Underflow at count 2
        drive(1, 2, 40'h6261, 0, 0, 0, 0);
        push(40'h6261, 2);
        step();
        drive(0, 0, '0, 1, 3, 0, 0);
        @(negedge clk);
        chk("und_valid", 64'(rd_valid), 64'd0);
        step();
        chk("und_flag", 64'(rd_underflow), 64'd1);
        chk("und_count", 64'(data_count), 64'd2);
        chk("und_rd_data", 64'(rd_data), 64'h00006261);
        drive(0, 0, '0, 0, 0, 0, 1);
        step();
        chk("und_clear", 64'(rd_underflow), 64'd0);
        drive(0, 0, '0, 1, 2, 0, 0);
        step();
        chk("drain_empty", 64'(empty), 64'd1);

        // Reset pulse during a write at count 9
        drive(1, 5, 40'h3534333231, 0, 0, 0, 0);
        step();
        drive(1, 4, 40'h39383736, 0, 0, 0, 0);
        step();
        chk("pre_rst_count", 64'(data_count), 64'd9);
        drive(1, 3, 40'hCCCCCC, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(data_count), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_rd_data", 64'(rd_data), 64'h0);
        idle();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_count", 64'(data_count), 64'd0);
        drive(1, 1, 40'h41, 0, 0, 0, 0);
        push(40'h41, 1);
        step();
        chk("postrst_w1_count", 64'(data_count), 64'd1);
        chk("postrst_w1_data", 64'(rd_data), 64'h00000041);
        drive(0, 0, '0, 1, 1, 0, 0);
        step();
        chk("final_empty", 64'(empty), 64'd1);
        chk("final_q_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_io_byte_fifo.md
MULTI_IO_BYTE_FIFO -- requirements
Module: multi_io_byte_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per byte lane.
REQ-002 Parameter FIFO_DEPTH, default 16, storage in bytes; SHALL be >= MAX_WR_BYTES and >= MAX_RD_BYTES.
REQ-003 Parameter MAX_WR_BYTES, default 5, maximum bytes written per cycle.
REQ-004 Parameter MAX_RD_BYTES, default 4, maximum bytes popped per cycle.
REQ-005 Parameter AFULL_THRESH, default FIFO_DEPTH-MAX_WR_BYTES, almost_full level in bytes.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 flush  input  1  synchronous clear of contents and error flags.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_data  input  DATA_WIDTH*MAX_WR_BYTES  write bytes; byte 0 in LSBs.
REQ-011 wr_len  input  $clog2(MAX_WR_BYTES+1)  bytes to write, 1..MAX_WR_BYTES.
REQ-012 wr_ready  output  1  combinational: the current wr_len fits this cycle.
REQ-013 rd_en  input  1  pop request.
REQ-014 rd_len  input  $clog2(MAX_RD_BYTES+1)  bytes to pop, 1..MAX_RD_BYTES.
REQ-015 rd_data  output  DATA_WIDTH*MAX_RD_BYTES  oldest bytes; oldest in LSBs; lanes at or above data_count read 0.
REQ-016 rd_valid  output  1  combinational: data_count >= rd_len and rd_len != 0.
REQ-017 data_count  output  $clog2(FIFO_DEPTH)+1  stored byte count (registered).
REQ-018 empty, almost_full, full  output  1 each  data_count==0, data_count>=AFULL_THRESH, data_count==FIFO_DEPTH.
REQ-019 wr_overflow, rd_underflow  output  1 each  sticky error flags.
REQ-020 clear_err  input  1  synchronous clear of the error flags only.

Function
REQ-021 Storage SHALL be a shift register, mem[0] oldest; rd_data is combinational from mem[0..MAX_RD_BYTES-1] (zero-latency peek).
REQ-022 Read accepted (rd_acc) iff rd_en && rd_valid; it removes rd_len bytes, shifting mem down by rd_len in one cycle.
REQ-023 Write accepted (wr_acc) iff wr_en && wr_len in 1..MAX_WR_BYTES && data_count - (rd_acc ? rd_len : 0) + wr_len <= FIFO_DEPTH; wr_ready equals this term without wr_en.
REQ-024 Writes are all-or-nothing: no partial write SHALL occur.
REQ-025 On a simultaneous rd_acc and wr_acc, the space freed by the read SHALL count, and write byte k lands at index data_count - rd_len + k.
REQ-026 data_count next = data_count - (rd_acc?rd_len:0) + (wr_acc?wr_len:0); arithmetic at least $clog2(FIFO_DEPTH)+2 bits wide, no wrap.
REQ-027 Vacated lanes at or above the new data_count SHALL be written 0.
REQ-028 Written bytes are visible on rd_data the cycle after acceptance.
REQ-029 wr_en with no accept (including wr_len 0 or > MAX_WR_BYTES) sets wr_overflow; state is unchanged.
REQ-030 rd_en with rd_valid low sets rd_underflow; state is unchanged.
REQ-031 flush has highest priority: next cycle data_count=0, mem all 0, errors 0; same-cycle reads and writes are ignored.
REQ-032 clear_err clears both flags; a new error in the same cycle wins (flag stays 1).

Reset
REQ-033 rst_n low SHALL asynchronously set mem to 0, data_count=0, wr_overflow=0, rd_underflow=0; hence empty=1, almost_full=0, full=0, rd_data=0.
REQ-034 Reset mid-operation SHALL discard all contents with no pending write completing; the first accepted operation after release behaves as from empty.

Verification
REQ-035 From reset: write wr_len=5 bytes 0x01..0x05 -> next cycle data_count=5, rd_data=0x04030201, rd_valid for rd_len<=4.
REQ-036 count=5, same cycle rd_len=3 and write wr_len=2 (0xAA,0xBB) -> count=4, rd_data=0xBBAA0504.
REQ-037 count=14 (default params): wr_len=3 rejected, wr_ready=0, wr_overflow=1, count stays 14; same wr_len with rd_len=2 -> accepted, count=15.
REQ-038 count=2, rd_en with rd_len=3 -> rd_underflow=1, count 2, data unchanged; clear_err -> flag 0.
REQ-039 count=16: full=1, almost_full=1; flush asserted with wr_en and rd_en -> count=0, empty=1, rd_data=0.
REQ-040 rst_n pulsed low mid-write with count=9 -> outputs return to reset values immediately; the next write of 1 byte gives count=1.
